// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg
//   Shared definitions for the MIPS load/store unit: opcode constants, the
//   FSM state type, the access size type and small opcode-decoding helpers.
//   No ports; imported by mips_lsu and mips_lsu_align.
package mips_lsu_pkg;

    // Opcodes of the supported MIPS loads and stores
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // True for any of the eight load/store opcodes the unit understands
    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Invalid opcodes decode as word size; they fault before size matters
    function automatic size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            default:              return SZ_W;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    // Byte accesses never fault; halfwords need an even address; words need
    // a multiple of four
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align
//   Combinational lane steering for big-endian MIPS sub-word accesses.
//   Ports:
//     i_size        access size (byte/half/word)
//     i_signed      1 = sign-extend loads (LB/LH)
//     i_addrLo      byte offset within the word, addr[1:0]
//     i_rdLanes     word read from memory, lane 0 = most significant byte
//     i_wdata       store data, sub-word stores use the low bits
//     o_loadData    extended load result
//     o_mergeLanes  read word with the store bytes substituted in
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  size_t            i_size,
    input  logic             i_signed,
    input  logic [1:0]       i_addrLo,
    input  logic [0:3][7:0]  i_rdLanes,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_loadData,
    output logic [0:3][7:0]  o_mergeLanes
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfword lanes are {addr[1],0} for the high byte and {addr[1],1} for
    // the low byte, so the pair is selected by addr[1] alone.
    always_comb begin
        w_byte = i_rdLanes[i_addrLo];
        w_half = {i_rdLanes[{i_addrLo[1], 1'b0}], i_rdLanes[{i_addrLo[1], 1'b1}]};

        o_loadData = i_rdLanes;
        case (i_size)
            SZ_B:    o_loadData = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_H:    o_loadData = {{16{i_signed & w_half[15]}}, w_half};
            SZ_W:    o_loadData = i_rdLanes;
            default: o_loadData = i_rdLanes;
        endcase

        o_mergeLanes = i_rdLanes;
        case (i_size)
            SZ_B: o_mergeLanes[i_addrLo] = i_wdata[7:0];
            SZ_H: begin
                o_mergeLanes[{i_addrLo[1], 1'b0}] = i_wdata[15:8];
                o_mergeLanes[{i_addrLo[1], 1'b1}] = i_wdata[7:0];
            end
            SZ_W:    o_mergeLanes = i_wdata;
            default: o_mergeLanes = i_wdata;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// mips_lsu
//   Load/store unit between the execute stage and a byte-lane data memory
//   without byte enables. One request at a time; sub-word stores are done
//   as read-modify-write. Completion is a one-cycle response pulse.
//   Parameters:
//     MEM_LATENCY     cycles from o_mem_addr stable to i_mem_data_out valid
//   Ports:
//     i_clk           clock, rising edge
//     i_rst_b         synchronous reset, active high
//     i_req_valid     request present
//     o_req_ready     unit idle; accept on valid && ready
//     i_req_opcode    MIPS opcode
//     i_req_addr      effective byte address
//     i_req_wdata     store data
//     o_rsp_valid     one-cycle completion pulse
//     o_rsp_rdata     extended load data, 0 for stores and faults
//     o_rsp_fault     misaligned address or unsupported opcode
//     o_mem_addr      word address
//     i_mem_data_out  read word, lane 0 = byte at addr+0 (MSB)
//     o_mem_data_in   write word, same lane order
//     o_mem_write_en  whole-word write strobe
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [5:0]       i_req_opcode,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    output logic             o_rsp_valid,
    output logic [31:0]      o_rsp_rdata,
    output logic             o_rsp_fault,
    output logic [31:0]      o_mem_addr,
    input  logic [0:3][7:0]  i_mem_data_out,
    output logic [0:3][7:0]  o_mem_data_in,
    output logic             o_mem_write_en
);

    localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    lsu_state_t        r_state;
    lsu_state_t        w_stateNext;

    logic [5:0]        r_opcode;
    logic [1:0]        r_addrLo;
    logic [31:0]       r_wdata;
    logic              r_fault;
    logic [CNT_W-1:0]  r_readCnt;
    logic [31:0]       r_memAddr;
    logic [31:0]       r_rspRdata;
    logic [0:3][7:0]   r_memDataIn;

    logic              w_accept;
    logic              w_reqFault;
    logic              w_readLast;
    size_t             w_reqSize;
    logic [31:0]       w_loadData;
    logic [0:3][7:0]   w_mergeLanes;

    // Fault classification is done on the live request so a faulting
    // request never touches memory.
    assign w_accept   = (r_state == IDLE) && i_req_valid;
    assign w_reqSize  = op_size(i_req_opcode);
    assign w_reqFault = !is_mem_op(i_req_opcode) ||
                        is_misaligned(w_reqSize, i_req_addr[1:0]);
    assign w_readLast = (r_state == READ) && (r_readCnt == CNT_LAST);

    mips_lsu_align u_align (
        .i_size       (op_size(r_opcode)),
        .i_signed     (op_signed(r_opcode)),
        .i_addrLo     (r_addrLo),
        .i_rdLanes    (i_mem_data_out),
        .i_wdata      (r_wdata),
        .o_loadData   (w_loadData),
        .o_mergeLanes (w_mergeLanes)
    );

    // State register; reset wins over any in-flight operation, which drops
    // a pending write and suppresses its response.
    always_ff @(posedge i_clk) begin
        if (i_rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state and the state-decoded outputs. Full-word stores skip the
    // read; sub-word stores read first so the untouched lanes survive.
    always_comb begin
        w_stateNext    = r_state;
        o_req_ready    = 1'b0;
        o_mem_write_en = 1'b0;
        o_rsp_valid    = 1'b0;
        o_rsp_fault    = 1'b0;
        case (r_state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_reqFault) begin
                        w_stateNext = RESP;
                    end else if (i_req_opcode == OP_SW) begin
                        w_stateNext = WRITE;
                    end else begin
                        w_stateNext = READ;
                    end
                end
            end
            READ: begin
                if (w_readLast) begin
                    w_stateNext = is_store(r_opcode) ? WRITE : RESP;
                end
            end
            WRITE: begin
                o_mem_write_en = 1'b1;
                w_stateNext    = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_fault = r_fault;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Request latch, latency counter, write buffer and response data.
    // The memory address is captured only on accept and then held, so the
    // request bus is free to change while the operation runs.
    always_ff @(posedge i_clk) begin
        if (i_rst_b) begin
            r_opcode    <= '0;
            r_addrLo    <= '0;
            r_wdata     <= '0;
            r_fault     <= 1'b0;
            r_readCnt   <= '0;
            r_memAddr   <= '0;
            r_rspRdata  <= '0;
            r_memDataIn <= '0;
        end else if (w_accept) begin
            r_opcode   <= i_req_opcode;
            r_addrLo   <= i_req_addr[1:0];
            r_wdata    <= i_req_wdata;
            r_fault    <= w_reqFault;
            r_readCnt  <= CNT_LOAD;
            r_memAddr  <= {i_req_addr[31:2], 2'b00};
            r_rspRdata <= '0;
            if ((i_req_opcode == OP_SW) && !w_reqFault) begin
                r_memDataIn <= i_req_wdata;
            end
        end else if (r_state == READ) begin
            if (w_readLast) begin
                if (is_store(r_opcode)) begin
                    r_memDataIn <= w_mergeLanes;
                end else begin
                    r_rspRdata <= w_loadData;
                end
            end else begin
                r_readCnt <= r_readCnt - 1'b1;
            end
        end
    end

    assign o_mem_addr    = r_memAddr;
    assign o_mem_data_in = r_memDataIn;
    assign o_rsp_rdata   = r_rspRdata;

endmodule
